// File: rtl/rom_streamer_pkg.sv
// rom_streamer_pkg: shared state encoding, default geometry and FIFO entry layout
package rom_streamer_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic last;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/rom_streamer_fifo.sv
// rom_streamer_fifo: synchronous FIFO with occupancy count, async active-low reset
module rom_streamer_fifo
  import rom_streamer_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/rom_streamer.sv
// rom_streamer: walks a wrap-around ROM address range and streams the words out with backpressure.
// Define ROM_STREAMER_CSUM_EN to add the running XOR checksum output csum.
module rom_streamer
  import rom_streamer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef ROM_STREAMER_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state, state_nx;
  logic [ADDR_W:0] rem;
  logic rd_vld, rd_last, accept, issue, pop;
  logic [CW-1:0] count;
  logic [CW+1:0] used;
  logic [DATA_W:0] head;
  assign accept = state == IDLE && start;
  assign pop = out_valid && out_ready;
  // credits after this edge: stored words plus reads in flight, including the one about to issue
  assign used = (CW+2)'(count) + (CW+2)'(rom_en) + (CW+2)'(rd_vld) - (CW+2)'(pop);
  assign issue = (accept && len != '0) || (state == RUN && rem != '0 && used < (CW+2)'(FIFO_DEPTH));
  assign out_valid = count != '0;
  assign out_data = out_valid ? head[DATA_W-1:0] : '0;
  assign out_last = out_valid && head[DATA_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (accept ? (len == '0 ? DONE : RUN) : IDLE) :
               state == RUN   ? (rem == '0 ? DRAIN : RUN) :
               state == DRAIN ? (pop && out_last ? DONE : DRAIN) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_en <= 1'b0;
      rom_addr <= '0;
      rem <= '0;
      rd_vld <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rom_en <= issue;
      rd_vld <= rom_en;
      rd_last <= rom_en && rem == '0;
      if (issue) begin
        rom_addr <= accept ? base_addr : rom_addr + 1'b1;
        rem <= (accept ? len : rem) - 1'b1;
      end
    end
  rom_streamer_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(rd_vld),
    .din({rd_last, rom_data}),
    .pop(pop),
    .dout(head),
    .count(count)
  );
`ifdef ROM_STREAMER_CSUM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum <= '0;
    else if (accept) csum <= '0;
    else if (pop) csum <= csum ^ out_data;
`endif
endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer: directed and randomized commands against a word-queue model of the stream
module tb_rom_streamer;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
  logic [4:0] base_addr = 0;
  logic [5:0] len = 0;
  logic busy, done, rom_en, out_valid, out_last;
  logic [4:0] rom_addr;
  logic [3:0] rom_data = 0, out_data;
  logic [3:0] rom [32];
  int checks = 0, failures = 0;
`ifdef ROM_STREAMER_CSUM_EN
  logic [3:0] csum;
`endif

  rom_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef ROM_STREAMER_CSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready always high, 1: ready low 5 cycles after 2nd word, 2: random ready
  task automatic run_cmd(input int b, input int n, input int mode, input bit restart);
    int q[$];
    int issued = 0, popped = 0, c = 0, hs = 0, stall_left = 5, first_v = 0;
    bit last_hs = 0, seen_done = 0, rdy;
    logic [3:0] x = 0;
    for (int i = 0; i < n; i++) q.push_back((i == n - 1 ? 16 : 0) + int'(rom[(b + i) % 32]));
    start = 1; base_addr = 5'(b); len = 6'(n);
    @(negedge clk);
    start = 0;
    while (!seen_done && c < 500) begin
      c++;
      rdy = mode == 0 ? 1'b1 : mode == 1 ? !(hs >= 2 && stall_left > 0) : ($urandom_range(0, 3) != 0);
      if (mode == 1 && hs >= 2 && stall_left > 0) stall_left--;
      out_ready = rdy;
      if (restart) begin
        start = (c == 4);
        base_addr = 5'($urandom);
        len = 6'($urandom_range(1, 32));
      end
      if (c == 1) chk("first_issue", rom_en, n != 0);
`ifdef ROM_STREAMER_CSUM_EN
      if (c == 1) chk("csum_clear", csum, 0);
      if (done === 1'b1) chk("csum_final", csum, x);
`endif
      if (rom_en === 1'b1) begin
        chk("rom_addr", rom_addr, (b + issued) % 32);
        issued++;
        chk("credit", issued - popped <= 4, 1);
      end
      chk("busy", busy, 1);
      chk("done", done, last_hs || (n == 0 && c == 1));
      seen_done = done === 1'b1;
      last_hs = 0;
      if (out_valid === 1'b1) begin
        chk("extra_word", q.size() != 0, 1);
        if (first_v == 0) first_v = c;
        if (q.size() != 0) begin
          chk("out_data", out_data, q[0] % 16);
          chk("out_last", out_last, q[0] / 16);
          if (rdy) begin
            x ^= 4'(q[0]);
            last_hs = q[0] >= 16;
            void'(q.pop_front());
            popped++;
            hs++;
          end
        end
      end
      @(negedge clk);
    end
    start = 0;
    chk("done_seen", seen_done, 1);
    chk("issued", issued, n);
    chk("words_left", q.size(), 0);
    if (mode == 0 && !restart) chk("done_cycle", c, n == 0 ? 1 : n + 3);
    if (mode == 0 && n > 0) chk("first_valid", first_v, 3);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
`ifdef ROM_STREAMER_CSUM_EN
    chk("csum_hold", csum, x);
`endif
    out_ready = 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rom_en"}, rom_en, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
`ifdef ROM_STREAMER_CSUM_EN
    chk({tag, "_csum"}, csum, 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 4'($urandom);
    #3 chk_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_cmd(0, 4, 0, 0);
    run_cmd(30, 4, 0, 0);
    run_cmd(8, 8, 1, 0);
    run_cmd(0, 0, 0, 0);
    run_cmd(3, 12, 0, 1);
    run_cmd(0, 32, 0, 0);
    run_cmd(17, 5, 0, 0);
    for (int k = 0; k < 6; k++) run_cmd(int'($urandom_range(0, 31)), int'($urandom_range(0, 32)), 2, 0);
    start = 1; base_addr = 5; len = 20;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    rst_n = 0;
    #1 chk_zero("abort");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_zero("post_reset");
    run_cmd(0, 2, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
